// File: rtl/ahb_s2m_mux.sv
// ahb_s2m_mux: AHB slave-to-master return mux with built-in default (error) slave
module ahb_s2m_mux #(
  parameter int HSLV_NUM   = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [1:0]            htrans_m,
  input  logic [HSLV_NUM-1:0]   hsel_m,
  input  logic [DATA_WIDTH-1:0] hrdata_s [0:HSLV_NUM-1],
  input  logic                  hready_s [0:HSLV_NUM-1],
  input  logic                  hresp_s  [0:HSLV_NUM-1],
  output logic [DATA_WIDTH-1:0] hrdata_m,
  output logic                  hready_m,
  output logic                  hresp_m,
  output logic [HSLV_NUM-1:0]   dsel_m,
  output logic                  err_multi
);
  typedef enum logic [1:0] {IDLE, SLV, ERR1, ERR2} state_t;
  state_t state, state_nxt;
  logic [HSLV_NUM-1:0] dsel_nxt;
  logic err_nxt, multi, sel_rdy, sel_resp;
  logic [DATA_WIDTH-1:0] sel_data;
  assign multi = (hsel_m & (hsel_m - HSLV_NUM'(1))) != '0;
  // AND-OR select of the data-phase slave; dsel_m is one-hot or zero
  always_comb begin
    sel_rdy  = 1'b0;
    sel_resp = 1'b0;
    sel_data = '0;
    for (int i = 0; i < HSLV_NUM; i++) begin
      sel_rdy  = sel_rdy  | (dsel_m[i] & hready_s[i]);
      sel_resp = sel_resp | (dsel_m[i] & hresp_s[i]);
      sel_data = sel_data | ({DATA_WIDTH{dsel_m[i]}} & hrdata_s[i]);
    end
    hready_m = state == SLV ? sel_rdy : state != ERR1;
    hresp_m  = state == SLV ? sel_resp : (state == ERR1 || state == ERR2);
    hrdata_m = state == SLV ? sel_data : '0;
  end
  // next data phase: sample the address phase only when the current data phase ends
  always_comb begin
    state_nxt = state;
    dsel_nxt  = dsel_m;
    err_nxt   = err_multi;
    if (state == ERR1) begin
      state_nxt = ERR2;
    end else if (hready_m) begin
      state_nxt = !htrans_m[1] ? IDLE : (hsel_m == '0 || multi) ? ERR1 : SLV;
      dsel_nxt  = (htrans_m[1] && hsel_m != '0 && !multi) ? hsel_m : '0;
      err_nxt   = err_multi | (htrans_m[1] & multi);
    end
  end
  // data-phase register and sticky decode-fault flag
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= IDLE;
      dsel_m    <= '0;
      err_multi <= 1'b0;
    end else begin
      state     <= state_nxt;
      dsel_m    <= dsel_nxt;
      err_multi <= err_nxt;
    end
  end
endmodule

// File: tb/tb_ahb_s2m_mux.sv
// tb_ahb_s2m_mux: scoreboard bench for ahb_s2m_mux against a transfer-level model
module tb_ahb_s2m_mux;
  localparam int N = 5;
  localparam int DW = 32;
  logic hclk = 1'b0;
  logic hresetn;
  logic [1:0] htrans_m;
  logic [N-1:0] hsel_m;
  logic [DW-1:0] hrdata_s [0:N-1];
  logic hready_s [0:N-1];
  logic hresp_s [0:N-1];
  logic [DW-1:0] hrdata_m;
  logic hready_m, hresp_m, err_multi;
  logic [N-1:0] dsel_m;

  ahb_s2m_mux #(.HSLV_NUM(N), .DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .htrans_m(htrans_m), .hsel_m(hsel_m),
    .hrdata_s(hrdata_s), .hready_s(hready_s), .hresp_s(hresp_s),
    .hrdata_m(hrdata_m), .hready_m(hready_m), .hresp_m(hresp_m),
    .dsel_m(dsel_m), .err_multi(err_multi)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic          rdy;
    logic          resp;
    logic [DW-1:0] data;
    logic [N-1:0]  dsel;
    logic          em;
  } exp_t;
  exp_t exp_q [$];

  int n_checks = 0;
  int n_fail = 0;

  // model: which slave owns the data phase (-1 none), remaining default-slave error cycles, sticky flag
  int tgt = -1;
  int errc = 0;
  bit em = 1'b0;
  bit chk_en = 1'b0;
  logic exp_rdy;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("hready_m", DW'(hready_m), DW'(e.rdy));
      cmp("hresp_m", DW'(hresp_m), DW'(e.resp));
      cmp("hrdata_m", hrdata_m, e.data);
      cmp("dsel_m", DW'(dsel_m), DW'(e.dsel));
      cmp("err_multi", DW'(err_multi), DW'(e.em));
    end
  end

  // one bus cycle: predict outputs for the inputs now applied, then advance the model across the edge
  task automatic tick();
    exp_t e;
    if (errc == 2) begin e.rdy = 0; e.resp = 1; e.data = '0; end
    else if (errc == 1) begin e.rdy = 1; e.resp = 1; e.data = '0; end
    else if (tgt >= 0) begin e.rdy = hready_s[tgt]; e.resp = hresp_s[tgt]; e.data = hrdata_s[tgt]; end
    else begin e.rdy = 1; e.resp = 0; e.data = '0; end
    e.dsel = tgt >= 0 ? N'(1) << tgt : '0;
    e.em = em;
    exp_rdy = e.rdy;
    if (chk_en) exp_q.push_back(e);
    @(posedge hclk);
    if (!hresetn) begin
      tgt = -1; errc = 0; em = 0;
    end else if (errc == 2) begin
      errc = 1;
    end else if (exp_rdy) begin
      errc = 0; tgt = -1;
      if (htrans_m[1]) begin
        if ($countones(hsel_m) == 1) begin
          for (int i = 0; i < N; i++) if (hsel_m[i]) tgt = i;
        end else begin
          errc = 2;
          if ($countones(hsel_m) > 1) em = 1;
        end
      end
    end
    #1;
  endtask

  task automatic addr(input logic [1:0] t, input logic [N-1:0] s);
    htrans_m = t;
    hsel_m = s;
  endtask

  task automatic slave_ok();
    for (int i = 0; i < N; i++) begin
      hready_s[i] = 1'b1;
      hresp_s[i] = 1'b0;
      hrdata_s[i] = 32'h5100_0000 + DW'(i);
    end
  endtask

  initial begin
    hresetn = 1'b0;
    addr(2'd0, '0);
    slave_ok();
    @(posedge hclk); #1;
    tick();
    tick();
    hresetn = 1'b1;
    chk_en = 1'b1;
    tick();
    // slave 2 with two wait states
    addr(2'd2, 5'b00100); tick();
    addr(2'd0, '0); hready_s[2] = 0; tick();
    tick();
    hready_s[2] = 1; hrdata_s[2] = 32'hCAFE_0002; tick();
    // unmapped -> default slave error, then idle
    slave_ok();
    addr(2'd2, '0); tick();
    addr(2'd0, '0); tick(); tick(); tick();
    // decode fault: two slaves selected
    addr(2'd2, 5'b00011); tick();
    addr(2'd0, '0); tick(); tick(); tick(); tick();
    // back-to-back slave1 then slave3
    addr(2'd3, 5'b00010); tick();
    addr(2'd3, 5'b01000); hrdata_s[1] = 32'h1111_0001; tick();
    addr(2'd0, '0); hrdata_s[3] = 32'h3333_0003; tick();
    tick();
    // reset during slave0 wait state
    addr(2'd2, 5'b00001); tick();
    addr(2'd0, '0); hready_s[0] = 0; tick();
    hresetn = 1'b0; tick();
    hresetn = 1'b1; tick(); tick();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      hresetn = $urandom_range(99) != 0;
      htrans_m = 2'($urandom_range(3));
      r = $urandom_range(9);
      hsel_m = r < 6 ? N'(1) << $urandom_range(N - 1) : r < 8 ? N'(0) : N'($urandom);
      for (int i = 0; i < N; i++) begin
        hready_s[i] = $urandom_range(9) < 7;
        hresp_s[i] = $urandom_range(9) == 0;
        hrdata_s[i] = $urandom;
      end
      tick();
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge hclk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
